// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency synchronous memory port between instruction
// fetch and load/store, with data priority and a bounded fetch starvation count.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              if_stall_o,
  output logic              d_stall_o
);

  localparam int WAIT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_D  = 3'd2,
    DONE_IF = 3'd3,
    DONE_D  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                d_ready_q, d_ready_d;
  logic                grant_d, grant_if;

  // Data wins unless a fetch is also pending and has already lost STARVE_MAX times.
  assign grant_d  = d_req_i && !(if_req_i && (starve_cnt_q == STARVE_TOP));
  assign grant_if = if_req_i && !grant_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ready_d   = 1'b0;
    d_ready_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = BUSY_D;
          wait_cnt_d  = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          if (if_req_i && (starve_cnt_q != STARVE_TOP)) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
          end
        end else if (grant_if) begin
          state_d      = BUSY_IF;
          wait_cnt_d   = '0;
          mem_en_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr_i;
          mem_wdata_d  = '0;
          starve_cnt_d = '0;
        end
      end

      BUSY_IF, BUSY_D: begin
        if (wait_cnt_q == WAIT_LAST) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (state_q == BUSY_IF) begin
            state_d    = DONE_IF;
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end else begin
            state_d   = DONE_D;
            d_ready_d = 1'b1;
            // Stores leave the previous load data visible.
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata_i;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      DONE_IF, DONE_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset_i) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ready_q   <= if_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign d_ready_o   = d_ready_q;

  assign if_stall_o  = if_req_i && !if_ready_q;
  assign d_stall_o   = d_req_i && !d_ready_q;

  a_ready_onehot : assert property (@(posedge clock_i) disable iff (reset_i)
    !(if_ready_q && d_ready_q));
  a_en_only_busy : assert property (@(posedge clock_i) disable iff (reset_i)
    (state_q inside {IDLE, DONE_IF, DONE_D}) |-> !mem_en_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2) with a small
// registered-read memory model attached to the shared port.
module tb_mem_port_arbiter;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ready_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [31:0] d_rdata_o;
  logic        d_ready_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        if_stall_o;
  logic        d_stall_o;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(2)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .if_stall_o(if_stall_o), .d_stall_o(d_stall_o)
  );

  always #5 clock_i = ~clock_i;

  // Memory model: one-cycle registered read, so data is valid on the 2nd BUSY cycle.
  logic [31:0] mem [0:255];
  always @(posedge clock_i) begin
    if (reset_i) begin
      mem[0]      <= 32'h1111_1111;
      mem[1]      <= 32'h2222_2222;
      mem[4]      <= 32'h0050_0093;
      mem[64]     <= 32'hAAAA_0100;
      mem[128]    <= 32'hBBBB_0200;
      mem_rdata_i <= 32'h0;
    end else if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_wdata_o;
      mem_rdata_i <= mem[mem_addr_o[9:2]];
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_starve [6] = '{0, 1, 2, 0, 1, 2};
    bit exp_if     [6] = '{0, 0, 1, 0, 0, 1};

    reset_i = 1'b1; if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    repeat (3) tick();
    check("rst_mem_en",   32'(mem_en_o), 0);
    check("rst_mem_we",   32'(mem_we_o), 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdat", mem_wdata_o, 0);
    check("rst_rdata",    if_rdata_o | d_rdata_o, 0);
    check("rst_ready",    {30'd0, if_ready_o, d_ready_o}, 0);
    check("rst_state",    32'(dut.state_q), 0);
    check("rst_starve",   32'(dut.starve_cnt_q), 0);
    check("rst_wait",     32'(dut.wait_cnt_q), 0);
    reset_i = 1'b0;
    tick();

    // Fetch only.
    if_req_i = 1'b1; if_addr_i = 32'h10; #1;
    check("f_stall_t0", 32'(if_stall_o), 1);
    check("f_en_t0",    32'(mem_en_o), 0);
    tick();
    check("f_en_t1",    32'(mem_en_o), 1);
    check("f_addr_t1",  mem_addr_o, 32'h10);
    check("f_we_t1",    32'(mem_we_o), 0);
    check("f_stall_t1", 32'(if_stall_o), 1);
    tick();
    check("f_en_t2",    32'(mem_en_o), 1);
    check("f_rdy_t2",   32'(if_ready_o), 0);
    check("f_stall_t2", 32'(if_stall_o), 1);
    tick();
    check("f_rdy_t3",   32'(if_ready_o), 1);
    check("f_drdy_t3",  32'(d_ready_o), 0);
    check("f_rdata",    if_rdata_o, 32'h0050_0093);
    check("f_en_t3",    32'(mem_en_o), 0);
    check("f_stall_t3", 32'(if_stall_o), 0);
    tick();
    if_req_i = 1'b0; #1;
    check("f_rdy_t4",   32'(if_ready_o), 0);
    check("f_state_t4", 32'(dut.state_q), 0);
    tick();
    check("f_en_t5",    32'(mem_en_o), 0);

    // Store then load of the same address.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h40; d_wdata_i = 32'hDEAD_BEEF; #1;
    check("s_stall_t0", 32'(d_stall_o), 1);
    tick();
    check("s_enwe_t1",  {30'd0, mem_en_o, mem_we_o}, 32'd3);
    check("s_addr_t1",  mem_addr_o, 32'h40);
    check("s_wdata_t1", mem_wdata_o, 32'hDEAD_BEEF);
    tick();
    check("s_we_t2",    32'(mem_we_o), 1);
    check("s_rdy_t2",   32'(d_ready_o), 0);
    tick();
    check("s_rdy_t3",   32'(d_ready_o), 1);
    check("s_we_t3",    32'(mem_we_o), 0);
    check("s_rdata",    d_rdata_o, 32'h0);
    tick();
    d_we_i = 1'b0; #1;
    check("l_rdy_t0",   32'(d_ready_o), 0);
    tick();
    check("l_enwe_t1",  {30'd0, mem_en_o, mem_we_o}, 32'd2);
    tick();
    tick();
    check("l_rdy_t3",   32'(d_ready_o), 1);
    check("l_rdata",    d_rdata_o, 32'hDEAD_BEEF);
    tick();
    d_req_i = 1'b0;
    tick();

    // Back-to-back fetches with if_req held.
    if_req_i = 1'b1; if_addr_i = 32'h0;
    tick();
    check("b_addr0",    mem_addr_o, 32'h0);
    tick();
    tick();
    check("b_rdy0",     32'(if_ready_o), 1);
    check("b_rdata0",   if_rdata_o, 32'h1111_1111);
    tick();
    if_addr_i = 32'h4; #1;
    check("b_gap1",     32'(if_ready_o), 0);
    tick();
    check("b_addr1",    mem_addr_o, 32'h4);
    check("b_en1",      32'(mem_en_o), 1);
    tick();
    check("b_gap3",     32'(if_ready_o), 0);
    tick();
    check("b_rdy1",     32'(if_ready_o), 1);
    check("b_rdata1",   if_rdata_o, 32'h2222_2222);
    tick();
    if_req_i = 1'b0;
    tick();

    // Both requesting continuously: grant order D, D, IF, D, D, IF.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200;
    for (int g = 0; g < 6; g++) begin
      n = 0;
      while (dut.state_q != 3'd0 && n < 8) begin
        tick();
        n++;
      end
      check($sformatf("arb%0d_idle_wait", g), 32'(n < 8), 1);
      check($sformatf("arb%0d_starve", g), 32'(dut.starve_cnt_q), exp_starve[g]);
      tick();
      check($sformatf("arb%0d_en", g), 32'(mem_en_o), 1);
      check($sformatf("arb%0d_addr", g), mem_addr_o, exp_if[g] ? 32'h100 : 32'h200);
      tick();
      tick();
      check($sformatf("arb%0d_ready", g), {30'd0, if_ready_o, d_ready_o},
            exp_if[g] ? 32'd2 : 32'd1);
      check($sformatf("arb%0d_rdata", g), exp_if[g] ? if_rdata_o : d_rdata_o,
            exp_if[g] ? 32'hAAAA_0100 : 32'hBBBB_0200);
      tick();
    end
    if_req_i = 1'b0; d_req_i = 1'b0;
    tick();

    // Reset during the first BUSY cycle of a store, then a normal load.
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h80; d_wdata_i = 32'h1234_5678;
    tick();
    check("r_we_busy1", 32'(mem_we_o), 1);
    reset_i = 1'b1;
    tick();
    check("r_enwe",     {30'd0, mem_en_o, mem_we_o}, 0);
    check("r_drdy",     32'(d_ready_o), 0);
    check("r_state",    32'(dut.state_q), 0);
    reset_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'h40;
    tick();
    check("r_en_after", 32'(mem_en_o), 1);
    check("r_drdy_t1",  32'(d_ready_o), 0);
    tick();
    tick();
    check("r_drdy_t3",  32'(d_ready_o), 1);
    check("r_rdata",    d_rdata_o, 32'hDEAD_BEEF);
    tick();
    d_req_i = 1'b0;
    tick();

    // Quiet port.
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("idle%0d_outs", c),
            {27'd0, mem_en_o, if_ready_o, d_ready_o, if_stall_o, d_stall_o}, 0);
      check($sformatf("idle%0d_starve", c), 32'(dut.starve_cnt_q), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
